// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI request scheduler and its request FIFO.
package spi_pkg;

    localparam int DEPTH_DEFAULT   = 32'd4;
    localparam int TIMEOUT_DEFAULT = 32'd64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } sched_state_t;

    typedef struct packed {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] data;
    } spi_req_t;

    // Saturating 8-bit increment used by the error counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'hFF) begin
            r = v;
        end else begin
            r = v + 8'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/spi_req_sched_if.sv
// Host request/response handshake plus the SPI-top side bus of the scheduler.
interface spi_req_sched_if;
    logic       req_valid;
    logic       req_ready;
    logic       req_wr;
    logic [7:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       rsp_timeout;
    logic       spi_req;
    logic       spi_wr;
    logic [7:0] spi_addr;
    logic [7:0] spi_din;
    logic [7:0] spi_dout;
    logic       spi_done;
    logic       spi_err;
    logic [7:0] err_count;

    // Scheduler side.
    modport slave (
        input  req_valid, req_wr, req_addr, req_wdata, rsp_ready,
               spi_dout, spi_done, spi_err,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
               spi_req, spi_wr, spi_addr, spi_din, err_count
    );

    // Host / SPI-stub side.
    modport master (
        output req_valid, req_wr, req_addr, req_wdata, rsp_ready,
               spi_dout, spi_done, spi_err,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
               spi_req, spi_wr, spi_addr, spi_din, err_count
    );
endinterface

// File: rtl/spi_req_fifo.sv
// Small synchronous FIFO of scheduler requests; DEPTH must be a power of two.
module spi_req_fifo
    import spi_pkg::*;
#(
    parameter  int DEPTH = DEPTH_DEFAULT,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  spi_req_t      din,
    input  logic          pop,
    output spi_req_t      dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    spi_req_t      mem_q [DEPTH];
    spi_req_t      mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok_s;
    logic          pop_ok_s;

    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == {CW{1'b0}});
    assign count     = count_q;
    assign dout      = mem_q[rd_ptr_q];
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;

    // Next storage, pointer and occupancy values; pointers wrap naturally at DEPTH.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok_s) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + AW'(1'b1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1'b1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + CW'(1'b1);
            2'b01:   count_d = count_q - CW'(1'b1);
            default: count_d = count_q;
        endcase
    end

    // FIFO state registers; reset empties the FIFO.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/spi_req_sched.sv
// Issues buffered host requests one at a time to the SPI top, waits for done/err
// or a timeout, and returns each result through a registered response port.
module spi_req_sched
    import spi_pkg::*;
#(
    parameter int DEPTH   = DEPTH_DEFAULT,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input logic            clk,
    input logic            rst,
    spi_req_sched_if.slave bus
);

    localparam int CW  = $clog2(TIMEOUT);
    localparam int FCW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

    sched_state_t   state_q, state_d;
    logic [CW-1:0]  wait_cnt_q, wait_cnt_d;
    logic           spi_req_q, spi_req_d;
    logic           spi_wr_q, spi_wr_d;
    logic [7:0]     spi_addr_q, spi_addr_d;
    logic [7:0]     spi_din_q, spi_din_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [7:0]     rsp_rdata_q, rsp_rdata_d;
    logic           rsp_err_q, rsp_err_d;
    logic           rsp_timeout_q, rsp_timeout_d;
    logic [7:0]     err_count_q, err_count_d;

    spi_req_t       req_in_s;
    spi_req_t       fifo_head_s;
    logic           fifo_full_s;
    logic           fifo_empty_s;
    logic [FCW-1:0] fifo_count_s;
    logic           push_s;
    logic           pop_s;

    assign req_in_s      = '{wr: bus.req_wr, addr: bus.req_addr, data: bus.req_wdata};
    assign push_s        = bus.req_valid && !fifo_full_s;
    // Ready depends on occupancy alone, never on req_valid.
    assign bus.req_ready = (fifo_count_s < FCW'(DEPTH));

    spi_req_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .din   (req_in_s),
        .pop   (pop_s),
        .dout  (fifo_head_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    // Scheduler FSM: next state, SPI drive, response capture and error counting.
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        spi_req_d     = spi_req_q;
        spi_wr_d      = spi_wr_q;
        spi_addr_d    = spi_addr_q;
        spi_din_d     = spi_din_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        err_count_d   = err_count_q;
        pop_s         = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty_s) begin
                    state_d = ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                pop_s      = 1'b1;
                spi_wr_d   = fifo_head_s.wr;
                spi_addr_d = fifo_head_s.addr;
                spi_din_d  = fifo_head_s.data;
                spi_req_d  = 1'b1;
                wait_cnt_d = {CW{1'b0}};
                state_d    = WAIT;
            end
            WAIT: begin
                // A done on the last counted cycle still beats the timeout.
                if (bus.spi_done) begin
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = spi_wr_q ? 8'h00 : bus.spi_dout;
                    rsp_err_d     = bus.spi_err;
                    rsp_timeout_d = 1'b0;
                    spi_req_d     = 1'b0;
                    state_d       = RESP;
                    if (bus.spi_err) begin
                        err_count_d = sat_inc8(err_count_q);
                    end else begin
                        err_count_d = err_count_q;
                    end
                end else if (wait_cnt_q == WAIT_LAST) begin
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = 8'h00;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    spi_req_d     = 1'b0;
                    state_d       = RESP;
                    err_count_d   = sat_inc8(err_count_q);
                end else begin
                    wait_cnt_d = wait_cnt_q + CW'(1'b1);
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    rsp_valid_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Scheduler registers; reset abandons any transaction without a response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            wait_cnt_q    <= {CW{1'b0}};
            spi_req_q     <= 1'b0;
            spi_wr_q      <= 1'b0;
            spi_addr_q    <= 8'h00;
            spi_din_q     <= 8'h00;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= 8'h00;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            err_count_q   <= 8'h00;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            spi_req_q     <= spi_req_d;
            spi_wr_q      <= spi_wr_d;
            spi_addr_q    <= spi_addr_d;
            spi_din_q     <= spi_din_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
            err_count_q   <= err_count_d;
        end
    end

    assign bus.spi_req     = spi_req_q;
    assign bus.spi_wr      = spi_wr_q;
    assign bus.spi_addr    = spi_addr_q;
    assign bus.spi_din     = spi_din_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.rsp_timeout = rsp_timeout_q;
    assign bus.err_count   = err_count_q;

endmodule

// File: tb/tb_spi_req_sched.sv
// Self-checking bench for spi_req_sched: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level model of the scheduler.
module tb_spi_req_sched;
    import spi_pkg::*;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 64;
    localparam int P_FREE  = 0;   // nothing in service
    localparam int P_POP   = 1;   // head is being handed to the SPI side
    localparam int P_BUSY  = 2;   // SPI transaction outstanding
    localparam int P_HOLD  = 3;   // response offered to host

    logic clk;
    logic rst;
    spi_req_sched_if bus ();

    spi_req_sched #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // model state
    spi_req_t mq[$];
    spi_req_t act;
    int       ph = P_FREE;
    int       edge_n = 0;
    int       wait_entry = 0;
    logic        e_spi_wr = 1'b0;
    logic [7:0]  e_spi_addr = 8'h00, e_spi_din = 8'h00;
    logic [7:0]  e_rdata = 8'h00, e_err_cnt = 8'h00;
    logic        e_err = 1'b0, e_to = 1'b0;

    // stimulus state
    spi_req_t   hq[$];
    logic [7:0] mem [256];
    int rr_mode = 1, rv_always = 1, lat_rand = 0, stub_lat = 5, stub_cnt = 0;
    int err_pct = 0, spur_en = 0;

    task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, a, e, $time);
        end
    endtask

    task automatic model_update();
        logic push;
        edge_n++;
        if (!rst) begin
            mq.delete();
            ph = P_FREE;
            e_spi_wr = 1'b0; e_spi_addr = 8'h00; e_spi_din = 8'h00;
            e_rdata = 8'h00; e_err = 1'b0; e_to = 1'b0; e_err_cnt = 8'h00;
            return;
        end
        push = bus.req_valid && (mq.size() < DEPTH);
        case (ph)
            P_FREE: if (mq.size() > 0) ph = P_POP;
            P_POP: begin
                act = mq.pop_front();
                e_spi_wr = act.wr; e_spi_addr = act.addr; e_spi_din = act.data;
                wait_entry = edge_n;
                ph = P_BUSY;
            end
            P_BUSY: begin
                if (bus.spi_done) begin
                    e_rdata = act.wr ? 8'h00 : bus.spi_dout;
                    e_err = bus.spi_err; e_to = 1'b0;
                    if (bus.spi_err && e_err_cnt != 8'hFF) e_err_cnt = e_err_cnt + 8'd1;
                    ph = P_HOLD;
                end else if (edge_n - wait_entry == TIMEOUT) begin
                    e_rdata = 8'h00; e_err = 1'b1; e_to = 1'b1;
                    if (e_err_cnt != 8'hFF) e_err_cnt = e_err_cnt + 8'd1;
                    ph = P_HOLD;
                end
            end
            default: if (bus.rsp_ready) ph = P_FREE;
        endcase
        if (push) begin
            mq.push_back('{wr: bus.req_wr, addr: bus.req_addr, data: bus.req_wdata});
            void'(hq.pop_front());
        end
    endtask

    task automatic compare();
        chk("req_ready", {31'd0, bus.req_ready}, {31'd0, mq.size() < DEPTH});
        chk("spi_req", {31'd0, bus.spi_req}, {31'd0, ph == P_BUSY});
        chk("spi_wr", {31'd0, bus.spi_wr}, {31'd0, e_spi_wr});
        chk("spi_addr", {24'd0, bus.spi_addr}, {24'd0, e_spi_addr});
        chk("spi_din", {24'd0, bus.spi_din}, {24'd0, e_spi_din});
        chk("rsp_valid", {31'd0, bus.rsp_valid}, {31'd0, ph == P_HOLD});
        chk("err_count", {24'd0, bus.err_count}, {24'd0, e_err_cnt});
        if (ph == P_HOLD || !rst) begin
            chk("rsp_rdata", {24'd0, bus.rsp_rdata}, {24'd0, e_rdata});
            chk("rsp_err", {31'd0, bus.rsp_err}, {31'd0, e_err});
            chk("rsp_timeout", {31'd0, bus.rsp_timeout}, {31'd0, e_to});
        end
    endtask

    task automatic drive();
        if (hq.size() > 0 && (rv_always != 0 || $urandom_range(3, 0) != 0)) begin
            bus.req_valid = 1'b1;
            bus.req_wr    = hq[0].wr;
            bus.req_addr  = hq[0].addr;
            bus.req_wdata = hq[0].data;
        end else begin
            bus.req_valid = 1'b0;
            bus.req_wr    = 1'($urandom);
            bus.req_addr  = 8'($urandom);
            bus.req_wdata = 8'($urandom);
        end
        case (rr_mode)
            0:       bus.rsp_ready = ($urandom_range(9, 0) < 7);
            1:       bus.rsp_ready = 1'b1;
            default: bus.rsp_ready = 1'b0;
        endcase
        bus.spi_done = 1'b0;
        bus.spi_err  = 1'b0;
        bus.spi_dout = 8'($urandom);
        if (bus.spi_req) begin
            if (stub_cnt == 0 && lat_rand != 0)
                stub_lat = ($urandom_range(19, 0) == 0) ? -1 : int'($urandom_range(12, 1));
            stub_cnt++;
            if (stub_cnt == stub_lat) begin
                bus.spi_done = 1'b1;
                bus.spi_err  = ($urandom_range(99, 0) < err_pct);
                if (bus.spi_wr) mem[bus.spi_addr] = bus.spi_din;
                else bus.spi_dout = mem[bus.spi_addr];
            end
        end else begin
            stub_cnt = 0;
            if (spur_en != 0 && $urandom_range(9, 0) == 0) begin
                bus.spi_done = 1'b1;
                bus.spi_err  = 1'($urandom);
            end
        end
    endtask

    task automatic step();
        drive();
        @(negedge clk);
        model_update();
        compare();
    endtask

    task automatic wait_spi_req(output int n);
        n = 0;
        do begin step(); n++; end while (!bus.spi_req && n < 300);
        chk("bound_spi_req", {31'd0, bus.spi_req}, 32'd1);
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        do begin step(); n++; end while (!bus.rsp_valid && n < 300);
        chk("bound_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
    endtask

    task automatic drain();
        int n = 0;
        while (!(hq.size() == 0 && mq.size() == 0 && ph == P_FREE) && n < 30000) begin
            step(); n++;
        end
        chk("drain_idle", {31'd0, hq.size() == 0 && mq.size() == 0 && ph == P_FREE}, 32'd1);
    endtask

    task automatic push_req(input logic wr, input logic [7:0] a, input logic [7:0] d);
        hq.push_back('{wr: wr, addr: a, data: d});
    endtask

    initial begin
        int n;
        logic [7:0] held;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        rst = 1'b0;
        bus.req_valid = 1'b0; bus.req_wr = 1'b0; bus.req_addr = 8'h00; bus.req_wdata = 8'h00;
        bus.rsp_ready = 1'b0; bus.spi_dout = 8'h00; bus.spi_done = 1'b0; bus.spi_err = 1'b0;
        repeat (3) step();
        chk("reset_req_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("reset_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        rst = 1'b1;

        // single write with a 5-cycle SPI latency
        stub_lat = 5;
        push_req(1'b1, 8'h10, 8'hA5);
        wait_spi_req(n);
        chk("t1_issue_latency", n, 32'd3);
        chk("t1_spi_wr", {31'd0, bus.spi_wr}, 32'd1);
        chk("t1_spi_addr", {24'd0, bus.spi_addr}, 32'h10);
        chk("t1_spi_din", {24'd0, bus.spi_din}, 32'hA5);
        wait_rsp(n);
        chk("t1_rsp_latency", n, 32'd5);
        chk("t1_rsp_rdata", {24'd0, bus.rsp_rdata}, 32'h00);
        chk("t1_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
        drain();

        // write then read back the same address
        push_req(1'b1, 8'h10, 8'hA5);
        push_req(1'b0, 8'h10, 8'h00);
        wait_rsp(n);
        chk("t2_wr_rdata", {24'd0, bus.rsp_rdata}, 32'h00);
        wait_rsp(n);
        chk("t2_rd_rdata", {24'd0, bus.rsp_rdata}, 32'hA5);
        drain();

        // five pushes against a slow SPI: FIFO fills behind the one in flight
        stub_lat = 40;
        for (int i = 0; i < 5; i++) push_req(1'b1, 8'(8'h20 + i), 8'($urandom));
        repeat (6) step();
        chk("t3_full_ready", {31'd0, bus.req_ready}, 32'd0);
        drain();

        // SPI never answers: timeout after exactly TIMEOUT WAIT cycles
        stub_lat = -1;
        push_req(1'b0, 8'h30, 8'h00);
        wait_spi_req(n);
        wait_rsp(n);
        chk("t4_timeout_latency", n, 32'd64);
        chk("t4_rsp_err", {31'd0, bus.rsp_err}, 32'd1);
        chk("t4_rsp_timeout", {31'd0, bus.rsp_timeout}, 32'd1);
        chk("t4_rsp_rdata", {24'd0, bus.rsp_rdata}, 32'h00);
        chk("t4_err_count", {24'd0, bus.err_count}, 32'd1);
        drain();

        // done on the final counted cycle wins over the timeout
        stub_lat = 64;
        push_req(1'b0, 8'h31, 8'h00);
        wait_spi_req(n);
        wait_rsp(n);
        chk("t5_done_latency", n, 32'd64);
        chk("t5_rsp_timeout", {31'd0, bus.rsp_timeout}, 32'd0);
        chk("t5_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
        chk("t5_err_count", {24'd0, bus.err_count}, 32'd1);
        drain();

        // host stalls the response for 10 cycles with more requests queued
        stub_lat = 3;
        rr_mode = 2;
        for (int i = 0; i < 3; i++) push_req(1'b0, 8'(8'h40 + i), 8'h00);
        wait_rsp(n);
        held = bus.rsp_rdata;
        repeat (10) step();
        chk("t6_rsp_held", {31'd0, bus.rsp_valid}, 32'd1);
        chk("t6_rdata_stable", {24'd0, bus.rsp_rdata}, {24'd0, held});
        chk("t6_no_issue", {31'd0, bus.spi_req}, 32'd0);
        rr_mode = 1;
        drain();

        // asynchronous reset in WAIT with three requests queued
        stub_lat = -1;
        for (int i = 0; i < 4; i++) push_req(1'b1, 8'(8'h50 + i), 8'(8'h60 + i));
        wait_spi_req(n);
        repeat (2) step();
        #2 rst = 1'b0;
        #1;
        chk("t7_req_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("t7_spi_req", {31'd0, bus.spi_req}, 32'd0);
        chk("t7_spi_addr", {24'd0, bus.spi_addr}, 32'd0);
        chk("t7_spi_din", {24'd0, bus.spi_din}, 32'd0);
        chk("t7_err_count", {24'd0, bus.err_count}, 32'd0);
        chk("t7_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        hq.delete();
        repeat (3) step();
        rst = 1'b1;
        repeat (30) step();
        chk("t7_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);

        // randomized traffic
        lat_rand = 1; rr_mode = 0; rv_always = 0; err_pct = 20; spur_en = 1;
        for (int i = 0; i < 300; i++)
            push_req(1'($urandom), 8'($urandom_range(15, 0)), 8'($urandom));
        drain();

        // error counter saturation
        lat_rand = 0; stub_lat = 1; rr_mode = 1; rv_always = 1; err_pct = 100; spur_en = 0;
        for (int i = 0; i < 260; i++) push_req(1'b1, 8'(i), 8'(i));
        drain();
        chk("t9_err_saturated", {24'd0, bus.err_count}, 32'd255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_req_sched.md
# spi_req_sched

Request scheduler sitting directly upstream of the SPI controller/memory top. It accepts host read/write requests through a valid/ready handshake, buffers them in a small FIFO, and issues them one at a time to the SPI top (`wr`/`addr`/`din`). It then waits for `done`/`err`, with a cycle timeout, and returns each result to the host through a registered valid/ready response port.

## Interface
Parameters:
- `DEPTH`, 4: request FIFO entries; power of two, at least 2.
- `TIMEOUT`, 64: maximum WAIT cycles before a transaction is abandoned; at least 2.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `req_valid` in 1: host request valid.
- `req_ready` out 1: FIFO can accept; equals `!full`.
- `req_wr` in 1: 1 = write, 0 = read.
- `req_addr` in 8: target address.
- `req_wdata` in 8: write data; ignored for reads.
- `rsp_valid` out 1: response valid.
- `rsp_ready` in 1: host accepts response.
- `rsp_rdata` out 8: read data; 0 for writes and timeouts.
- `rsp_err` out 1: SPI `err` seen, or timeout.
- `rsp_timeout` out 1: transaction abandoned by timeout.
- `spi_req` out 1: transaction active toward SPI top.
- `spi_wr` out 1: drives SPI top `wr`.
- `spi_addr` out 8: drives SPI top `addr`.
- `spi_din` out 8: drives SPI top `din`.
- `spi_dout` in 8: from SPI top `dout`.
- `spi_done` in 1: from SPI top `done`; single-cycle pulse.
- `spi_err` in 1: from SPI top `err`; qualified by `spi_done`.
- `err_count` out 8: saturating count of error responses.

## Operation
- FIFO:
  - Push on `req_valid && req_ready`. Pop occurs only in ISSUE.
  - Push and pop in the same cycle leave the count unchanged.
  - Pointers wrap modulo `DEPTH`. The count ranges 0..`DEPTH`.
- FSM states: IDLE, ISSUE, WAIT, RESP.
  - IDLE goes to ISSUE when the FIFO is non-empty.
  - ISSUE lasts 1 cycle. It latches the head entry into `spi_wr`/`spi_addr`/`spi_din`, pops the FIFO, sets `spi_req=1`, clears the wait counter, then goes to WAIT.
  - In WAIT, `spi_done=1` captures `rsp_rdata` (read: `spi_dout`; write: 0) and `rsp_err=spi_err`, sets `rsp_timeout=0`, then goes to RESP.
  - In WAIT, when the wait counter reaches `TIMEOUT-1` with no `spi_done`: `rsp_rdata=0`, `rsp_err=1`, `rsp_timeout=1`, then go to RESP.
  - If `spi_done` arrives in the same cycle the counter reaches `TIMEOUT-1`, `spi_done` wins and no timeout is flagged.
  - RESP holds `rsp_valid=1` and all `rsp_*` stable until `rsp_ready`, then goes to IDLE.
- `spi_req` is 1 in ISSUE (registered, visible the cycle after entry) and in WAIT. It drops on the cycle RESP is entered.
- `spi_wr`/`spi_addr`/`spi_din` hold their last value outside active transactions. Only one transaction is outstanding.
- `spi_done` pulses outside WAIT are ignored.
- `err_count` increments when RESP is entered with `rsp_err=1`. It saturates at 255.
- Reset (asynchronous, any state, mid-transaction included):
  - FIFO emptied; FSM goes to IDLE.
  - All outputs 0, except `req_ready=1`.
  - An abandoned transaction produces no response.

## Timing
- All outputs are registered, except `req_ready`, which is combinational from the FIFO count only. There is no path from `req_valid` to `req_ready`.
- Request push at edge 0 into an empty FIFO with FSM in IDLE:
  - ISSUE active after edge 1.
  - `spi_req`/`spi_addr` valid after edge 2 (WAIT).
- `spi_done` sampled at edge N gives `rsp_valid=1` after edge N.
- `rsp_ready` sampled high at edge M: `rsp_valid=0` after M, IDLE; the next ISSUE after M+1.
- Back-to-back throughput: 1 transaction per (SPI latency + 3 + response stall) cycles.
- The wait counter is `$clog2(TIMEOUT)` bits wide. It counts WAIT cycles and never wraps.

## Structure
- Shared package `spi_pkg`:
  - `sched_state_t` enum (IDLE, ISSUE, WAIT, RESP).
  - `spi_req_t` packed struct {wr, addr[7:0], data[7:0]}.
  - Defaults for `DEPTH` and `TIMEOUT`.
- Sub-module `spi_req_fifo`: parameterised synchronous FIFO of `spi_req_t`. Provides push/pop/full/empty/count, using the same clock and reset.
- FSM, wait counter, response registers and `err_count` live in `spi_req_sched`.

## Test plan
- Single write, addr=0x10, data=0xA5; SPI `done` 5 cycles later, `err=0` -> `spi_wr=1`, `spi_addr=0x10`, `spi_din=0xA5` held through WAIT; response `rsp_valid=1`, `rsp_err=0`, `rsp_rdata=0x00`.
- Write then read of 0x10; stub returns `dout=0xA5` -> two responses in order, second has `rsp_rdata=0xA5`; no overlap of `spi_req`.
- Push 5 requests with `DEPTH=4` while SPI stalled -> `req_ready=0` after the 4th push beyond the one in flight; responses appear in push order; count never exceeds 4.
- SPI never asserts `done`, `TIMEOUT=64` -> `rsp_valid` rises 64 cycles after WAIT entry with `rsp_err=1`, `rsp_timeout=1`, `rsp_rdata=0`; `err_count=1`; `done` on the counter's final cycle gives no timeout.
- `rsp_ready` held low 10 cycles with 2 requests queued -> response held stable, no second ISSUE until accepted.
- Assert `rst` low during WAIT with 3 queued -> all outputs 0 immediately (`req_ready=1`), FIFO empty, no response after release; `err_count` = 0.
